// File: rtl/alu_sequencer_pkg.sv
// Shared types for the ALU sequencer: op encoding, direction, FSM states, decode.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package alu_sequencer_pkg;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        MUL = 3'd2,
        DIV = 3'd3,
        SHL = 3'd4,
        SHR = 3'd5,
        ROL = 3'd6,
        ROR = 3'd7
    } alu_op_e;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } op_dir_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } alu_seq_state_e;

    // One-hot ALU strobes plus shift/rotate direction.
    typedef struct packed {
        logic    add;
        logic    sub;
        logic    mul;
        logic    div;
        logic    shift;
        logic    rot;
        op_dir_e dir;
    } alu_ctrl_t;

    // Encoded op -> strobe set. Exactly one strobe is set for every encoding;
    // direction is only meaningful for shift/rotate and defaults to LEFT.
    function automatic alu_ctrl_t decode_op(alu_op_e op);
        alu_ctrl_t c;
        c = '0;
        case (op)
            ADD: c.add = 1'b1;
            SUB: c.sub = 1'b1;
            MUL: c.mul = 1'b1;
            DIV: c.div = 1'b1;
            SHL: c.shift = 1'b1;
            SHR: begin
                c.shift = 1'b1;
                c.dir   = RIGHT;
            end
            ROL: c.rot = 1'b1;
            ROR: begin
                c.rot = 1'b1;
                c.dir = RIGHT;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_sequencer_arbiter.sv
// 2-way round-robin arbiter: grants the lone requester, or the one not granted last.
// Latency: combinational grant; last_grant updates on the edge a grant is taken.
// Backpressure: no grant while enable is low; every enabled grant is a handshake.
//
// Ports: clock/reset (sync, active-high), enable (grants allowed this cycle),
// valid[1:0] (request present per requester), grant (winning index),
// grant_valid (a grant is being issued this cycle).
module alu_rr_arbiter
    import alu_sequencer_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] valid,
    output logic       grant,
    output logic       grant_valid
);

    // Reset to 1 so requester 0 wins the first contested cycle.
    logic last_grant;

    always_comb begin
        grant = valid[1];
        if (valid == 2'b11) begin
            grant = ~last_grant;
        end
        grant_valid = enable & (|valid);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (grant_valid) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Two-requester front end for the shared 8-bit ALU: arbitrate, decode, issue, capture, respond.
// Latency: response 3 cycles after accept (1 cycle for divide-by-zero); 1 op per 4 cycles max.
// Backpressure: response held stable until rsp_ready; no request accepted until it is taken.
//
// Ports: clock/reset (sync, active-high); req0_*/req1_* valid/ready request channels
// with op, a, b; rsp_* response channel (valid/ready, id, result, zero, err);
// alu_* control outputs to the ALU (operands, enable, one-hot strobes, direction)
// and alu_result, the ALU's registered result.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter logic [7:0] DIV0_RESULT = 8'hFF
) (
    input  logic       clock,
    input  logic       reset,

    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [2:0] req0_op,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,

    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [2:0] req1_op,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,

    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_result,
    output logic       rsp_zero,
    output logic       rsp_err,

    output logic [7:0] alu_register1,
    output logic [7:0] alu_register2,
    output logic       alu_out,
    output logic       alu_op_add,
    output logic       alu_op_sub,
    output logic       alu_op_mul,
    output logic       alu_op_div,
    output logic       alu_op_shift,
    output logic       alu_op_rot,
    output op_dir_e    alu_op_dir,
    input  logic [7:0] alu_result
);

    alu_seq_state_e state;
    alu_ctrl_t      ctrl_q;

    logic       grant;
    logic       grant_valid;
    alu_op_e    sel_op;
    logic [7:0] sel_a;
    logic [7:0] sel_b;

    alu_rr_arbiter u_arb (
        .clock       (clock),
        .reset       (reset),
        .enable      (state == IDLE),
        .valid       ({req1_valid, req0_valid}),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // grant_valid already implies IDLE and that the granted requester is valid,
    // so it doubles as the accept strobe.
    assign req0_ready = grant_valid & (grant == 1'b0);
    assign req1_ready = grant_valid & (grant == 1'b1);

    always_comb begin
        sel_op = alu_op_e'(grant ? req1_op : req0_op);
        sel_a  = grant ? req1_a : req0_a;
        sel_b  = grant ? req1_b : req0_b;
    end

    assign alu_op_add   = ctrl_q.add;
    assign alu_op_sub   = ctrl_q.sub;
    assign alu_op_mul   = ctrl_q.mul;
    assign alu_op_div   = ctrl_q.div;
    assign alu_op_shift = ctrl_q.shift;
    assign alu_op_rot   = ctrl_q.rot;
    assign alu_op_dir   = ctrl_q.dir;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            ctrl_q        <= '0;
            alu_out       <= 1'b0;
            alu_register1 <= 8'd0;
            alu_register2 <= 8'd0;
            rsp_valid     <= 1'b0;
            rsp_id        <= 1'b0;
            rsp_result    <= 8'd0;
            rsp_zero      <= 1'b0;
            rsp_err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        alu_register1 <= sel_a;
                        alu_register2 <= sel_b;
                        rsp_id        <= grant;
                        // Divide-by-zero never reaches the ALU; answer directly.
                        if (sel_op == DIV && sel_b == 8'd0) begin
                            rsp_result <= DIV0_RESULT;
                            rsp_err    <= 1'b1;
                            rsp_zero   <= 1'b0;
                            rsp_valid  <= 1'b1;
                            state      <= RESP;
                        end else begin
                            ctrl_q  <= decode_op(sel_op);
                            alu_out <= 1'b1;
                            state   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // Strobes live for exactly this one cycle.
                    ctrl_q  <= '0;
                    alu_out <= 1'b0;
                    state   <= CAPTURE;
                end
                CAPTURE: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= (alu_result == 8'd0);
                    rsp_err    <= 1'b0;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: transaction-level reference model plus directed and random stimulus.
// Latency: n/a.
// Backpressure: rsp_ready is driven directly (held low, high, or random).
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [2:0] req0_op, req1_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
    logic [7:0] rsp_result;
    logic [7:0] alu_register1, alu_register2;
    logic       alu_out, alu_op_add, alu_op_sub, alu_op_mul, alu_op_div, alu_op_shift, alu_op_rot;
    op_dir_e    alu_op_dir;
    logic [7:0] alu_result = 8'd0;

    always #5 clock = ~clock;

    alu_sequencer dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_register1(alu_register1), .alu_register2(alu_register2), .alu_out(alu_out),
        .alu_op_add(alu_op_add), .alu_op_sub(alu_op_sub), .alu_op_mul(alu_op_mul), .alu_op_div(alu_op_div),
        .alu_op_shift(alu_op_shift), .alu_op_rot(alu_op_rot), .alu_op_dir(alu_op_dir),
        .alu_result(alu_result)
    );

    // Expected result of an op, straight from the arithmetic rules.
    function automatic logic [7:0] exp_res(alu_op_e op, logic [7:0] a, logic [7:0] b);
        logic [7:0] r;
        case (op)
            ADD: r = a + b;
            SUB: r = a - b;
            MUL: r = a * b;
            DIV: r = (b == 8'd0) ? 8'hFF : a / b;
            SHL: r = a << 1;
            SHR: r = a >> 1;
            ROL: r = {a[6:0], a[7]};
            default: r = {a[0], a[7:1]};
        endcase
        return r;
    endfunction

    // Stand-in ALU: registers a result whenever it is enabled.
    function automatic logic [7:0] emu_alu();
        logic [7:0] r;
        r = 8'h5A;
        if (alu_op_add) r = alu_register1 + alu_register2;
        else if (alu_op_sub) r = alu_register1 - alu_register2;
        else if (alu_op_mul) r = alu_register1 * alu_register2;
        else if (alu_op_div) r = (alu_register2 == 8'd0) ? 8'h00 : alu_register1 / alu_register2;
        else if (alu_op_shift) r = (alu_op_dir == LEFT) ? alu_register1 << 1 : alu_register1 >> 1;
        else if (alu_op_rot) r = (alu_op_dir == LEFT) ? {alu_register1[6:0], alu_register1[7]}
                                                      : {alu_register1[0], alu_register1[7:1]};
        return r;
    endfunction

    always @(posedge clock) begin
        if (alu_out) alu_result <= emu_alu();
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one op in flight, timed from its accept cycle.
    int         cyc = 0;
    bit         m_busy = 0;
    int         m_t = 0;
    bit         m_div0 = 0;
    alu_op_e    m_op = ADD;
    logic [7:0] m_a = 0, m_b = 0, m_r1 = 0, m_r2 = 0;
    bit         m_id = 0;
    bit         m_last = 1;
    bit         p_acc = 0, p_hs = 0, p_id = 0;
    alu_op_e    p_op = ADD;
    logic [7:0] p_a = 0, p_b = 0;

    task automatic compare();
        bit iss, rv, gv, g;
        logic [7:0] r;
        iss = m_busy && !m_div0 && (cyc == m_t + 1);
        chk("alu_out", alu_out, iss);
        chk("op_add", alu_op_add, iss && m_op == ADD);
        chk("op_sub", alu_op_sub, iss && m_op == SUB);
        chk("op_mul", alu_op_mul, iss && m_op == MUL);
        chk("op_div", alu_op_div, iss && m_op == DIV);
        chk("op_shift", alu_op_shift, iss && (m_op == SHL || m_op == SHR));
        chk("op_rot", alu_op_rot, iss && (m_op == ROL || m_op == ROR));
        chk("op_dir", alu_op_dir, iss && (m_op == SHR || m_op == ROR));
        chk("strobe_onehot",
            $countones({alu_op_add, alu_op_sub, alu_op_mul, alu_op_div, alu_op_shift, alu_op_rot}) <= 1, 1);
        rv = m_busy && (cyc >= m_t + (m_div0 ? 1 : 3));
        chk("rsp_valid", rsp_valid, rv);
        if (rv) begin
            r = exp_res(m_op, m_a, m_b);
            chk("rsp_result", rsp_result, r);
            chk("rsp_zero", rsp_zero, r == 8'd0);
            chk("rsp_err", rsp_err, m_div0);
            chk("rsp_id", rsp_id, m_id);
        end
        chk("alu_reg1", alu_register1, m_r1);
        chk("alu_reg2", alu_register2, m_r2);
        gv = !m_busy && (req0_valid || req1_valid);
        g  = (req0_valid && req1_valid) ? !m_last : req1_valid;
        chk("req0_ready", req0_ready, gv && !g);
        chk("req1_ready", req1_ready, gv && g);
        p_acc = gv;
        p_id  = g;
        p_op  = alu_op_e'(g ? req1_op : req0_op);
        p_a   = g ? req1_a : req0_a;
        p_b   = g ? req1_b : req0_b;
        p_hs  = rv && rsp_ready;
    endtask

    task automatic model_edge();
        cyc++;
        if (reset) begin
            m_busy = 0; m_last = 1; m_r1 = 0; m_r2 = 0;
        end else if (p_hs) begin
            m_busy = 0;
        end else if (p_acc) begin
            m_busy = 1; m_t = cyc - 1; m_op = p_op; m_a = p_a; m_b = p_b; m_id = p_id;
            m_div0 = (p_op == DIV) && (p_b == 8'd0);
            m_last = p_id; m_r1 = p_a; m_r2 = p_b;
        end
        p_acc = 0; p_hs = 0;
    endtask

    // Caller sets inputs just after an edge; this checks the cycle and advances one edge.
    task automatic step();
        #1;
        compare();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic set_req(input int n, input bit v, input alu_op_e op, input logic [7:0] a, input logic [7:0] b);
        if (n == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    initial begin
        bit have_prev, prev_id, cur_id;
        reset = 1; rsp_ready = 0;
        set_req(0, 0, ADD, 0, 0);
        set_req(1, 0, ADD, 0, 0);
        @(posedge clock);
        model_edge();
        #1;
        chk("rst_alu_out", alu_out, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_flags", {rsp_id, rsp_zero, rsp_err}, 0);
        chk("rst_regs", {alu_register1, alu_register2}, 0);
        chk("rst_dir", alu_op_dir, LEFT);
        step();
        reset = 0;

        // ADD 200+100 wraps to 44.
        rsp_ready = 1;
        set_req(0, 1, ADD, 8'd200, 8'd100);
        #1 chk("add_ready0", req0_ready, 1);
        step();
        req0_valid = 0;
        chk("add_issue", {alu_out, alu_op_add}, 2'b11);
        step(); step();
        chk("add_rsp", {rsp_valid, rsp_result, rsp_zero, rsp_err, rsp_id}, {1'b1, 8'd44, 3'b000});
        step();

        // Both requesters continuously valid: grants must alternate.
        set_req(0, 1, SUB, 8'd5, 8'd5);
        set_req(1, 1, ROL, 8'h81, 8'd0);
        have_prev = 0; prev_id = 0;
        repeat (17) begin
            step();
            if (req0_ready || req1_ready) begin
                cur_id = req1_ready;
                if (have_prev) chk("rr_alternate", cur_id, !prev_id);
                prev_id = cur_id; have_prev = 1;
            end
            if (rsp_valid) begin
                chk("rr_result", rsp_result, rsp_id ? 8'h03 : 8'h00);
                chk("rr_zero", rsp_zero, !rsp_id);
            end
        end
        req0_valid = 0; req1_valid = 0;
        repeat (6) step();

        // Divide by zero answered without the ALU.
        rsp_ready = 0;
        set_req(1, 1, DIV, 8'd9, 8'd0);
        step();
        req1_valid = 0;
        chk("div0_rsp", {rsp_valid, rsp_result, rsp_err, rsp_zero, rsp_id}, {1'b1, 8'hFF, 3'b101});
        chk("div0_no_alu", alu_out, 0);
        rsp_ready = 1;
        step(); step();

        // SHR under response backpressure with both requesters waiting.
        rsp_ready = 0;
        set_req(0, 1, SHR, 8'h80, 8'd3);
        step();
        set_req(1, 1, ADD, 8'd1, 8'd1);
        chk("shr_dir_issue", alu_op_dir, RIGHT);
        step(); step();
        repeat (5) begin
            chk("shr_hold", {rsp_valid, rsp_result, rsp_id}, {1'b1, 8'h40, 1'b0});
            chk("shr_no_ready", {req0_ready, req1_ready}, 2'b00);
            chk("shr_dir_left", alu_op_dir, LEFT);
            step();
        end
        rsp_ready = 1;
        step();
        req0_valid = 0; req1_valid = 0;
        repeat (6) step();

        // Reset while MUL is in ISSUE: op discarded, arbitration restarts with req0.
        set_req(1, 1, MUL, 8'd16, 8'd16);
        step();
        req1_valid = 0;
        chk("mul_issue", {alu_out, alu_op_mul}, 2'b11);
        reset = 1;
        step();
        reset = 0;
        chk("mul_rst_quiet", {alu_out, alu_op_mul, rsp_valid}, 3'b000);
        repeat (5) begin
            chk("mul_no_rsp", rsp_valid, 0);
            step();
        end
        set_req(0, 1, ADD, 8'd1, 8'd2);
        set_req(1, 1, SUB, 8'd7, 8'd3);
        #1 chk("post_rst_grant", {req0_ready, req1_ready}, 2'b10);
        step();
        req0_valid = 0; req1_valid = 0;
        repeat (6) step();

        // Random traffic, backpressure and occasional reset.
        repeat (1500) begin
            set_req(0, $urandom_range(0, 9) < 6, alu_op_e'($urandom_range(0, 7)), 8'($urandom),
                    ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom));
            set_req(1, $urandom_range(0, 9) < 6, alu_op_e'($urandom_range(0, 7)), 8'($urandom),
                    ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom));
            rsp_ready = $urandom_range(0, 9) < 7;
            reset = $urandom_range(0, 199) == 0;
            step();
        end
        reset = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
